// File: rtl/peripheral_bus_bridge.sv
// Avalon-MM slave bridge: decodes one word-addressed bus into register and memory ports,
// keeping read responses in issue order and answering unmapped register reads locally.
module peripheral_bus_bridge #(
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned NUM_REGS    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [8:0]  avs_address,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  output logic        avs_readdatavalid,
  output logic [31:0] avs_readdata,
  output logic        reg_read,
  output logic        reg_write,
  output logic [1:0]  reg_address,
  output logic [31:0] reg_data_in,
  input  logic        reg_read_valid,
  input  logic [31:0] reg_data_out,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_data_in,
  input  logic        mem_read_valid,
  input  logic [31:0] mem_data_out,
  output logic        err_spurious
);

  localparam int unsigned CW = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {TgtReg, TgtMem, TgtLocal} tgt_e;

  tgt_e          dec;
  tgt_e          tgt_q, tgt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          local_q, local_d;
  logic          rdv_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q;

  logic          stall, acc_rd, src_valid, resp, spurious;
  logic [31:0]   src_data;

  always_comb begin
    if (avs_address[8]) begin
      dec = TgtMem;
    end else if (32'(avs_address[7:0]) < NUM_REGS) begin
      dec = TgtReg;
    end else begin
      dec = TgtLocal;
    end
  end

  always_comb begin
    // Stall uses the registered count only; a response landing this cycle frees a slot next cycle.
    stall  = avs_read && ((cnt_q == CW'(MAX_PENDING)) || ((cnt_q != '0) && (dec != tgt_q)));
    acc_rd = avs_read && !stall;

    case (tgt_q)
      TgtReg: begin
        src_valid = reg_read_valid;
        src_data  = reg_data_out;
      end
      TgtMem: begin
        src_valid = mem_read_valid;
        src_data  = mem_data_out;
      end
      default: begin
        src_valid = local_q;
        src_data  = 32'h0000_0000;
      end
    endcase

    resp     = src_valid && (cnt_q != '0);
    spurious = (reg_read_valid && !((tgt_q == TgtReg) && (cnt_q != '0))) ||
               (mem_read_valid && !((tgt_q == TgtMem) && (cnt_q != '0)));

    cnt_d = cnt_q;
    if (acc_rd && !resp) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!acc_rd && resp) begin
      cnt_d = cnt_q - CW'(1);
    end

    tgt_d   = acc_rd ? dec : tgt_q;
    local_d = acc_rd && (dec == TgtLocal);
    rdata_d = resp ? src_data : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      tgt_q   <= TgtReg;
      local_q <= 1'b0;
      rdv_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      local_q <= local_d;
      rdv_q   <= resp;
      rdata_q <= rdata_d;
      err_q   <= err_q | spurious;
    end
  end

  assign avs_waitrequest   = stall;
  assign avs_readdatavalid = rdv_q;
  assign avs_readdata      = rdata_q;
  assign err_spurious      = err_q;

  assign reg_read    = acc_rd && (dec == TgtReg);
  assign reg_write   = avs_write && (dec == TgtReg);
  assign reg_address = avs_address[1:0];
  assign reg_data_in = avs_writedata;
  assign mem_read    = acc_rd && (dec == TgtMem);
  assign mem_write   = avs_write && (dec == TgtMem);
  assign mem_address = avs_address[7:0];
  assign mem_data_in = avs_writedata;

endmodule

// File: tb/tb_peripheral_bus_bridge.sv
// Randomized bench for peripheral_bus_bridge: peripheral stand-ins plus an in-order
// expected-response queue as reference model.
module tb_peripheral_bus_bridge;

  localparam int MAXP = 4;
  localparam int NREG = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [8:0]  avs_address = '0;
  logic [31:0] avs_writedata = '0;
  logic        avs_waitrequest, avs_readdatavalid;
  logic [31:0] avs_readdata;
  logic        reg_read, reg_write;
  logic [1:0]  reg_address;
  logic [31:0] reg_data_in;
  logic        reg_read_valid = 1'b0;
  logic [31:0] reg_data_out = '0;
  logic        mem_read, mem_write;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in;
  logic        mem_read_valid = 1'b0;
  logic [31:0] mem_data_out = '0;
  logic        err_spurious;

  peripheral_bus_bridge #(.MAX_PENDING(MAXP), .NUM_REGS(NREG)) dut (
    .clk(clk), .reset(reset),
    .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
    .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
    .avs_readdatavalid(avs_readdatavalid), .avs_readdata(avs_readdata),
    .reg_read(reg_read), .reg_write(reg_write), .reg_address(reg_address),
    .reg_data_in(reg_data_in), .reg_read_valid(reg_read_valid), .reg_data_out(reg_data_out),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_read_valid(mem_read_valid), .mem_data_out(mem_data_out),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Peripheral stand-ins: in-order responders with per-request latency.
  typedef struct {int due; logic [31:0] data;} rsp_t;
  logic [31:0] reg_arr[4];
  logic [31:0] mem_arr[256];
  rsp_t        reg_pq[$];
  rsp_t        mem_pq[$];
  bit          hold_mem = 0;
  bit          rand_rsp = 0;
  int          cyc = 0;

  // Reference model: expected read data in issue order, plus current target.
  logic [31:0] ref_reg[4];
  logic [31:0] ref_mem[256];
  logic [31:0] exp_q[$];
  int          m_tgt = 0;   // 0 reg, 1 mem, 2 local
  bit          m_local = 0;
  bit          m_err = 0;
  bit          exp_rdv = 0;
  logic [31:0] exp_rdata = '0;

  task automatic cycle(input bit rd, input bit wr, input logic [8:0] a, input logic [31:0] wd,
                       input bit inj_mem);
    int dec;
    bit e_wait, acc, src, resp, spur;
    @(posedge clk);
    #1;
    cyc++;
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;
    reg_read_valid = 1'b0; mem_read_valid = 1'b0;
    if (reg_pq.size() > 0 && reg_pq[0].due <= cyc && (!rand_rsp || $urandom_range(0, 3) != 0)) begin
      reg_read_valid = 1'b1; reg_data_out = reg_pq[0].data; reg_pq.delete(0);
    end
    if (mem_pq.size() > 0 && mem_pq[0].due <= cyc && !hold_mem &&
        (!rand_rsp || $urandom_range(0, 3) != 0)) begin
      mem_read_valid = 1'b1; mem_data_out = mem_pq[0].data; mem_pq.delete(0);
    end
    if (inj_mem) begin
      mem_read_valid = 1'b1; mem_data_out = $urandom;
    end
    #3;
    dec    = a[8] ? 1 : ((a[7:0] < NREG) ? 0 : 2);
    e_wait = rd && (exp_q.size() == MAXP || (exp_q.size() != 0 && dec != m_tgt));
    acc    = rd && !e_wait;
    check("waitrequest", avs_waitrequest, e_wait);
    check("reg_read", reg_read, acc && dec == 0);
    check("reg_write", reg_write, wr && dec == 0);
    check("mem_read", mem_read, acc && dec == 1);
    check("mem_write", mem_write, wr && dec == 1);
    if ((acc || wr) && dec == 0) check("reg_address", reg_address, a[1:0]);
    if ((acc || wr) && dec == 1) check("mem_address", mem_address, a[7:0]);
    if (wr && dec == 0) check("reg_data_in", reg_data_in, wd);
    if (wr && dec == 1) check("mem_data_in", mem_data_in, wd);
    check("readdatavalid", avs_readdatavalid, exp_rdv);
    check("readdata", avs_readdata, exp_rdata);
    check("err_spurious", err_spurious, m_err);
    // Peripherals react to whatever the DUT actually strobes.
    if (reg_write) reg_arr[reg_address] = reg_data_in;
    if (mem_write) mem_arr[mem_address] = mem_data_in;
    if (reg_read)
      reg_pq.push_back('{due: cyc + (rand_rsp ? int'($urandom_range(1, 3)) : 1),
                         data: reg_arr[reg_address]});
    if (mem_read)
      mem_pq.push_back('{due: cyc + (rand_rsp ? int'($urandom_range(1, 4)) : 1),
                         data: mem_arr[mem_address]});
    // Reference update for the coming edge.
    src  = (m_tgt == 0) ? reg_read_valid : ((m_tgt == 1) ? mem_read_valid : m_local);
    resp = src && exp_q.size() != 0;
    spur = (reg_read_valid && !(m_tgt == 0 && exp_q.size() != 0)) ||
           (mem_read_valid && !(m_tgt == 1 && exp_q.size() != 0));
    if (resp) exp_rdata = exp_q.pop_front();
    exp_rdv = resp;
    if (acc) begin
      m_tgt = dec;
      exp_q.push_back(dec == 0 ? ref_reg[a[1:0]] : (dec == 1 ? ref_mem[a[7:0]] : 32'h0));
    end
    if (wr && dec == 0) ref_reg[a[1:0]] = wd;
    if (wr && dec == 1) ref_mem[a[7:0]] = wd;
    m_local = acc && dec == 2;
    m_err   = m_err | spur;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 9'h0, 32'h0, 1'b0);
  endtask

  // Hold a command until accepted, bounded.
  task automatic issue(input bit rd, input bit wr, input logic [8:0] a, input logic [31:0] wd);
    int n = 0;
    do begin
      cycle(rd, wr, a, wd, 1'b0);
      n++;
    end while (avs_waitrequest && n < 60);
    if (avs_waitrequest) check("issue_timeout", avs_waitrequest, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_rdv) && n < 200) begin
      idle(1);
      n++;
    end
    if (exp_q.size() != 0) check("drain_pending", 32'(exp_q.size()), 32'h0);
    idle(1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    avs_read = 1'b0; avs_write = 1'b0;
    reg_read_valid = 1'b0; mem_read_valid = 1'b0;
    #1;
    check("rst_readdatavalid", avs_readdatavalid, 1'b0);
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_err_spurious", err_spurious, 1'b0);
    check("rst_waitrequest", avs_waitrequest, 1'b0);
    reg_pq.delete(); mem_pq.delete(); exp_q.delete();
    m_tgt = 0; m_local = 0; m_err = 0; exp_rdv = 0; exp_rdata = '0; hold_mem = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int tsel;
    logic [8:0] a;
    for (int i = 0; i < 4; i++) begin reg_arr[i] = '0; ref_reg[i] = '0; end
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem_arr[i] = 32'h10 + 32'(i);
      ref_mem[i] = mem_arr[i];
    end
    #2;
    apply_reset();

    // Register write then read back.
    issue(1'b0, 1'b1, 9'h000, 32'hA5A5_0001);
    issue(1'b1, 1'b0, 9'h000, 32'h0);
    drain();

    // Back-to-back memory burst with fixed single-cycle latency.
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 9'h100 + 9'(i), 32'h0);
    drain();

    // Fill to MAX_PENDING with memory withheld; fifth read stalls.
    hold_mem = 1;
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 9'h100 + 9'(i), 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 9'h104, 32'h0, 1'b0);
    hold_mem = 0;
    issue(1'b1, 1'b0, 9'h104, 32'h0);
    drain();

    // Target switch memory -> register.
    issue(1'b1, 1'b0, 9'h105, 32'h0);
    issue(1'b1, 1'b0, 9'h001, 32'h0);
    drain();

    // Unmapped read and write.
    issue(1'b1, 1'b0, 9'h003, 32'h0);
    issue(1'b0, 1'b1, 9'h0FF, 32'hDEAD_BEEF);
    drain();

    // Randomized traffic with varying latency and gaps.
    rand_rsp = 1;
    tsel = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 2) tsel = $urandom_range(0, 2);
      case (tsel)
        0:       a = 9'($urandom_range(0, NREG - 1));
        1:       a = {1'b1, 8'($urandom)};
        default: a = 9'($urandom_range(NREG, 255));
      endcase
      case ($urandom_range(0, 9))
        0, 1:    idle(1);
        2, 3:    issue(1'b0, 1'b1, a, $urandom);
        default: issue(1'b1, 1'b0, a, 32'h0);
      endcase
    end
    drain();
    rand_rsp = 0;

    // Spurious response, then reset with two memory reads in flight.
    cycle(1'b0, 1'b0, 9'h0, 32'h0, 1'b1);
    idle(2);
    hold_mem = 1;
    issue(1'b1, 1'b0, 9'h110, 32'h0);
    issue(1'b1, 1'b0, 9'h111, 32'h0);
    idle(2);
    apply_reset();
    idle(4);
    issue(1'b1, 1'b0, 9'h002, 32'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
